// File: rtl/cbus_ram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cbus_ram_responder_pkg
// Description : Cache-bus request/response types and encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package cbus_ram_responder_pkg;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;

    localparam logic [2:0] c_SIZE_BYTE  = 3'd0;
    localparam logic [2:0] c_SIZE_HALF  = 3'd1;
    localparam logic [2:0] c_SIZE_WORD  = 3'd2;
    localparam logic [2:0] c_SIZE_DWORD = 3'd3;

    // len carries the beat count minus one
    localparam int c_LEN_W = 4;

    typedef struct packed {
        logic               valid;
        logic               is_write;
        logic [2:0]         size;
        logic [31:0]        addr;
        logic [7:0]         strobe;
        logic [63:0]        data;
        logic [c_LEN_W-1:0] len;
        logic [1:0]         burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage
`default_nettype wire

// File: rtl/cbus_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : cbus_ram_array
// Description : 64-bit word storage, async read port, byte-enable sync write.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_ram_array #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [63:0]           o_rd_data,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [7:0]            i_wr_strobe,
    input  logic [63:0]           i_wr_data
);

    logic [63:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (i_wr_strobe[i]) begin
                    r_mem[i_wr_addr][8*i +: 8] <= i_wr_data[8*i +: 8];
                end
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/cbus_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : cbus_ram_responder
// Description : Cache-bus slave RAM with first-beat latency and FIXED/INCR bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_ram_responder
    import cbus_ram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  ireq,
    output cbus_resp_t oresp,
    output logic       busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_BURST = 2'd2;

    localparam int         c_LAT_W    = 4;
    localparam logic [c_LAT_W-1:0] c_LAT_LAST =
        (LATENCY > 0) ? c_LAT_W'(LATENCY - 1) : '0;

    logic [1:0]            r_state;
    logic                  r_is_write;
    logic [1:0]            r_burst;
    logic [c_LEN_W-1:0]    r_len;
    logic [c_LEN_W-1:0]    r_cnt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [c_LAT_W-1:0]    r_lat;

    logic                  w_beat;
    logic                  w_last;
    logic [63:0]           w_rd_data;
    logic                  w_unused_ok;

    // A beat only happens while the initiator still holds valid; a drop is an abort
    assign w_beat = (r_state == c_ST_BURST) && ireq.valid;
    assign w_last = (r_cnt == r_len);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= c_ST_IDLE;
            r_is_write <= 1'b0;
            r_burst    <= c_BURST_FIXED;
            r_len      <= '0;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_lat      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (ireq.valid) begin
                        r_is_write <= ireq.is_write;
                        r_burst    <= ireq.burst;
                        r_len      <= ireq.len;
                        r_ptr      <= ireq.addr[ADDR_WIDTH+2:3];
                        r_cnt      <= '0;
                        r_lat      <= '0;
                        r_state    <= (LATENCY > 0) ? c_ST_WAIT : c_ST_BURST;
                    end
                end
                c_ST_WAIT: begin
                    if (!ireq.valid) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_lat == c_LAT_LAST) begin
                        r_state <= c_ST_BURST;
                    end else begin
                        r_lat <= r_lat + 4'd1;
                    end
                end
                c_ST_BURST: begin
                    if (!ireq.valid) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_burst == c_BURST_INCR) begin
                            r_ptr <= r_ptr + ADDR_WIDTH'(1);
                        end
                        if (w_last) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    cbus_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk         (clk),
        .i_rd_addr   (r_ptr),
        .o_rd_data   (w_rd_data),
        .i_wr_en     (w_beat && r_is_write),
        .i_wr_addr   (r_ptr),
        .i_wr_strobe (ireq.strobe),
        .i_wr_data   (ireq.data)
    );

    assign oresp.ready = w_beat;
    assign oresp.last  = w_beat && w_last;
    assign oresp.data  = (w_beat && !r_is_write) ? w_rd_data : 64'd0;
    assign busy        = (r_state != c_ST_IDLE);

    // size is ignored and address bits outside the word index alias
    assign w_unused_ok = &{1'b0, ireq.size, ireq.addr};

endmodule
`default_nettype wire
